memory_access_stage: RTL and testbench

- Memory stage of the RISC-V pipeline, consuming the execute-stage outputs: ALU result (address or data), load/store codes, store data, rd address and write-back controls.
- Performs aligned byte/half/word loads and stores against a data memory over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers a write-back bundle for the write-back stage.

---
 rtl/memory_access_stage.sv | 194 +++++++++++++++++++
 tb/tb_memory_access_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Memory stage: issues aligned byte/half/word accesses over a req/ack port,
// stalls upstream while a transaction is outstanding, and registers the write-back bundle.
module memory_access_stage #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADD_WIDTH    = 5,
  parameter int D_CACHE_LW_WIDTH = 3,
  parameter int D_CACHE_SW_WIDTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
  input  logic [DATA_WIDTH-1:0]       ALU_IN,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
  input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
  input  logic [DATA_WIDTH-1:0]       DATA_CACHE_STORE_DATA,
  input  logic                        WRITE_BACK_MUX_SELECT_IN,
  input  logic                        RD_WRITE_ENABLE_IN,
  output logic                        MEM_REQ,
  output logic                        MEM_WE,
  output logic [ADDRESS_WIDTH-1:0]    MEM_ADDR,
  output logic [3:0]                  MEM_WSTRB,
  output logic [DATA_WIDTH-1:0]       MEM_WDATA,
  input  logic [DATA_WIDTH-1:0]       MEM_RDATA,
  input  logic                        MEM_ACK,
  output logic                        STALL_OUT,
  output logic                        MISALIGNED,
  output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
  output logic [DATA_WIDTH-1:0]       WB_DATA_OUT,
  output logic                        RD_WRITE_ENABLE_OUT
);

  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LB  = 1;
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LBU = 2;
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LH  = 3;
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LHU = 4;
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LW  = 5;
  localparam logic [D_CACHE_SW_WIDTH-1:0] ST_SB  = 1;
  localparam logic [D_CACHE_SW_WIDTH-1:0] ST_SH  = 2;
  localparam logic [D_CACHE_SW_WIDTH-1:0] ST_SW  = 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                        r_req;
  logic                        r_we;
  logic [ADDRESS_WIDTH-1:0]    r_addr;
  logic [3:0]                  r_wstrb;
  logic [DATA_WIDTH-1:0]       r_wdata;
  logic [DATA_WIDTH-1:0]       r_rdata;
  logic [1:0]                  r_lsb;
  logic [D_CACHE_LW_WIDTH-1:0] r_ld;
  logic                        r_mis_p1;
  logic [REG_ADD_WIDTH-1:0]    r_rd_addr_p1;
  logic [DATA_WIDTH-1:0]       r_wb_data_p1;
  logic                        r_rd_we_p1;

  logic w_is_load;
  logic w_is_store;
  logic w_access;
  logic w_half;
  logic w_word;
  logic w_misaligned;
  logic w_issue;

  function automatic logic [3:0] f_wstrb(input logic [D_CACHE_SW_WIDTH-1:0] st,
                                         input logic [1:0] a);
    case (st)
      ST_SB:   return 4'b0001 << a;
      ST_SH:   return 4'b0011 << a;
      ST_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_wdata(input logic [D_CACHE_SW_WIDTH-1:0] st,
                                                    input logic [DATA_WIDTH-1:0] d);
    case (st)
      ST_SB:   return {4{d[7:0]}};
      ST_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [DATA_WIDTH-1:0] f_load(input logic [D_CACHE_LW_WIDTH-1:0] ld,
                                                   input logic [1:0] a,
                                                   input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (ld)
      LD_LB:   return {{24{b[7]}}, b};
      LD_LBU:  return {24'd0, b};
      LD_LH:   return {{16{h[15]}}, h};
      LD_LHU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    w_is_load  = (DATA_CACHE_LOAD_IN >= LD_LB) && (DATA_CACHE_LOAD_IN <= LD_LW);
    w_is_store = (DATA_CACHE_STORE_IN != '0);
    w_access   = w_is_load || w_is_store;
    if (w_is_store) begin
      w_half = (DATA_CACHE_STORE_IN == ST_SH);
      w_word = (DATA_CACHE_STORE_IN == ST_SW);
    end else begin
      w_half = (DATA_CACHE_LOAD_IN == LD_LH) || (DATA_CACHE_LOAD_IN == LD_LHU);
      w_word = (DATA_CACHE_LOAD_IN == LD_LW);
    end
    w_misaligned = w_access && ((w_half && ALU_IN[0]) || (w_word && (ALU_IN[1:0] != 2'b00)));
    w_issue      = (r_state == S_IDLE) && w_access && !w_misaligned;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_REQ;
      S_REQ:   if (MEM_ACK) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage boundary: request registers and write-back bundle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_lsb        <= '0;
      r_ld         <= '0;
      r_mis_p1     <= 1'b0;
      r_rd_addr_p1 <= '0;
      r_wb_data_p1 <= '0;
      r_rd_we_p1   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mis_p1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {ALU_IN[ADDRESS_WIDTH-1:2], 2'b00};
            r_wstrb <= f_wstrb(DATA_CACHE_STORE_IN, ALU_IN[1:0]);
            r_wdata <= f_wdata(DATA_CACHE_STORE_IN, DATA_CACHE_STORE_DATA);
            r_lsb   <= ALU_IN[1:0];
            r_ld    <= DATA_CACHE_LOAD_IN;
          end else begin
            r_mis_p1     <= w_misaligned;
            r_rd_addr_p1 <= RD_ADDRESS_IN;
            r_wb_data_p1 <= ALU_IN;
            r_rd_we_p1   <= RD_WRITE_ENABLE_IN && !w_misaligned;
          end
        end
        S_REQ: begin
          if (MEM_ACK) begin
            r_req   <= 1'b0;
            r_rdata <= MEM_RDATA;
          end
        end
        S_DONE: begin
          r_rd_addr_p1 <= RD_ADDRESS_IN;
          r_wb_data_p1 <= WRITE_BACK_MUX_SELECT_IN ? f_load(r_ld, r_lsb, r_rdata) : ALU_IN;
          r_rd_we_p1   <= RD_WRITE_ENABLE_IN;
        end
        default: ;
      endcase
    end
  end

  assign MEM_REQ             = r_req;
  assign MEM_WE              = r_we;
  assign MEM_ADDR            = r_addr;
  assign MEM_WSTRB           = r_wstrb;
  assign MEM_WDATA           = r_wdata;
  assign STALL_OUT           = w_issue || (r_state == S_REQ);
  assign MISALIGNED          = r_mis_p1;
  assign RD_ADDRESS_OUT      = r_rd_addr_p1;
  assign WB_DATA_OUT         = r_wb_data_p1;
  assign RD_WRITE_ENABLE_OUT = r_rd_we_p1;

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage: byte-addressed reference memory,
// bench-side memory responder and directed boundary cases.
module tb_memory_access_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  RD_ADDRESS_IN;
  logic [31:0] ALU_IN;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic [31:0] DATA_CACHE_STORE_DATA;
  logic        WRITE_BACK_MUX_SELECT_IN;
  logic        RD_WRITE_ENABLE_IN;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_WSTRB;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        STALL_OUT;
  logic        MISALIGNED;
  logic [4:0]  RD_ADDRESS_OUT;
  logic [31:0] WB_DATA_OUT;
  logic        RD_WRITE_ENABLE_OUT;

  memory_access_stage dut (
    .CLK                      (CLK),
    .RST_N                    (RST_N),
    .RD_ADDRESS_IN            (RD_ADDRESS_IN),
    .ALU_IN                   (ALU_IN),
    .DATA_CACHE_LOAD_IN       (DATA_CACHE_LOAD_IN),
    .DATA_CACHE_STORE_IN      (DATA_CACHE_STORE_IN),
    .DATA_CACHE_STORE_DATA    (DATA_CACHE_STORE_DATA),
    .WRITE_BACK_MUX_SELECT_IN (WRITE_BACK_MUX_SELECT_IN),
    .RD_WRITE_ENABLE_IN       (RD_WRITE_ENABLE_IN),
    .MEM_REQ                  (MEM_REQ),
    .MEM_WE                   (MEM_WE),
    .MEM_ADDR                 (MEM_ADDR),
    .MEM_WSTRB                (MEM_WSTRB),
    .MEM_WDATA                (MEM_WDATA),
    .MEM_RDATA                (MEM_RDATA),
    .MEM_ACK                  (MEM_ACK),
    .STALL_OUT                (STALL_OUT),
    .MISALIGNED               (MISALIGNED),
    .RD_ADDRESS_OUT           (RD_ADDRESS_OUT),
    .WB_DATA_OUT              (WB_DATA_OUT),
    .RD_WRITE_ENABLE_OUT      (RD_WRITE_ENABLE_OUT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] dmem  [16];
  logic [7:0]  ref_b [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    dmem[idx] = val;
    for (int k = 0; k < 4; k++) ref_b[4*idx+k] = val[8*k +: 8];
  endtask

  function automatic int op_bytes(input logic [2:0] ld, input logic [1:0] st);
    if (st != 0) return 1 << (st - 1);
    case (ld)
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      3'd5:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [31:0] a);
    int          base;
    logic [7:0]  b;
    logic [15:0] h;
    base = int'(a[5:0]);
    b    = ref_b[base];
    h    = {ref_b[(base+1) % 64], ref_b[base]};
    case (ld)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
    endcase
  endfunction

  task automatic drive_idle();
    RD_ADDRESS_IN            = '0;
    ALU_IN                   = '0;
    DATA_CACHE_LOAD_IN       = '0;
    DATA_CACHE_STORE_IN      = '0;
    DATA_CACHE_STORE_DATA    = '0;
    WRITE_BACK_MUX_SELECT_IN = 1'b0;
    RD_WRITE_ENABLE_IN       = 1'b0;
  endtask

  // Presents one instruction at a negedge and holds it until it retires.
  task automatic run_op(input string nm, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [2:0] ld, input logic [1:0] st, input logic [31:0] sd,
                        input logic sel, input logic we, input int ack_after);
    int          nb, a0, stalls, reqs, idx;
    bit          acc, mis, done, stl;
    logic [31:0] exp_strb, exp_wdata, exp_load, exp_wb;
    nb  = op_bytes(ld, st);
    acc = (nb != 0);
    a0  = int'(alu[1:0]);
    mis = acc && ((a0 % nb) != 0);
    exp_strb  = '0;
    exp_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      exp_strb[k] = (st != 0) && (k >= a0) && (k < a0 + nb);
      if (nb != 0) exp_wdata[8*k +: 8] = sd[8*(k % nb) +: 8];
    end
    exp_load = ref_load(ld, alu);

    RD_ADDRESS_IN            = rd;
    ALU_IN                   = alu;
    DATA_CACHE_LOAD_IN       = ld;
    DATA_CACHE_STORE_IN      = st;
    DATA_CACHE_STORE_DATA    = sd;
    WRITE_BACK_MUX_SELECT_IN = sel;
    RD_WRITE_ENABLE_IN       = we;
    MEM_ACK                  = 1'b0;
    stalls = 0;
    reqs   = 0;
    done   = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      stl = STALL_OUT;
      if (stl) stalls++;
      MEM_ACK   = 1'b0;
      MEM_RDATA = $urandom;
      if (MEM_REQ) begin
        reqs++;
        if (reqs == 1) begin
          chk({nm, "_addr"}, MEM_ADDR, {alu[31:2], 2'b00});
          chk({nm, "_we"}, 32'(MEM_WE), 32'(st != 0));
          if (st != 0) begin
            chk({nm, "_wstrb"}, 32'(MEM_WSTRB), exp_strb);
            chk({nm, "_wdata"}, MEM_WDATA, exp_wdata);
          end
        end
        if (reqs == ack_after) begin
          MEM_ACK = 1'b1;
          idx = int'(MEM_ADDR[5:2]);
          if (MEM_WE) begin
            for (int k = 0; k < 4; k++)
              if (MEM_WSTRB[k]) dmem[idx][8*k +: 8] = MEM_WDATA[8*k +: 8];
          end else begin
            MEM_RDATA = dmem[idx];
          end
        end
      end
      @(negedge CLK);
      if (!stl) done = 1;
    end
    MEM_ACK = 1'b0;
    chk({nm, "_retired"}, 32'(done), 32'd1);

    if (acc && !mis) exp_wb = sel ? exp_load : alu;
    else             exp_wb = alu;
    chk({nm, "_stalls"}, 32'(stalls), (acc && !mis) ? 32'(1 + ack_after) : 32'd0);
    chk({nm, "_reqcyc"}, 32'(reqs), (acc && !mis) ? 32'(ack_after) : 32'd0);
    chk({nm, "_req_low"}, 32'(MEM_REQ), 32'd0);
    chk({nm, "_mis"}, 32'(MISALIGNED), 32'(mis));
    chk({nm, "_rd"}, 32'(RD_ADDRESS_OUT), 32'(rd));
    chk({nm, "_wbdata"}, WB_DATA_OUT, exp_wb);
    chk({nm, "_rdwe"}, 32'(RD_WRITE_ENABLE_OUT), 32'(we && !mis));

    if (acc && !mis && st != 0)
      for (int k = 0; k < 4; k++)
        if (exp_strb[k]) ref_b[{alu[5:2], 2'b00} + k] = exp_wdata[8*k +: 8];
  endtask

  initial begin
    RST_N     = 1'b0;
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    drive_idle();
    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    repeat (2) @(negedge CLK);
    chk("rst_req", 32'(MEM_REQ), 32'd0);
    chk("rst_we", 32'(MEM_WE), 32'd0);
    chk("rst_addr", MEM_ADDR, 32'd0);
    chk("rst_wstrb", 32'(MEM_WSTRB), 32'd0);
    chk("rst_wdata", MEM_WDATA, 32'd0);
    chk("rst_mis", 32'(MISALIGNED), 32'd0);
    chk("rst_rd", 32'(RD_ADDRESS_OUT), 32'd0);
    chk("rst_wb", WB_DATA_OUT, 32'd0);
    chk("rst_rdwe", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    chk("rst_stall", 32'(STALL_OUT), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset while a load is outstanding, then a stray ack in IDLE.
    ALU_IN = 32'h0000_1008; DATA_CACHE_LOAD_IN = 3'd5; RD_ADDRESS_IN = 5'd9;
    RD_WRITE_ENABLE_IN = 1'b1; WRITE_BACK_MUX_SELECT_IN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("midrst_req_before", 32'(MEM_REQ), 32'd1);
    #2;
    RST_N = 1'b0;
    drive_idle();
    #1;
    chk("midrst_req", 32'(MEM_REQ), 32'd0);
    chk("midrst_addr", MEM_ADDR, 32'd0);
    chk("midrst_stall", 32'(STALL_OUT), 32'd0);
    @(negedge CLK);
    RST_N   = 1'b1;
    MEM_ACK = 1'b1;
    MEM_RDATA = 32'hDEAD_BEEF;
    repeat (2) @(negedge CLK);
    chk("stray_ack_req", 32'(MEM_REQ), 32'd0);
    chk("stray_ack_stall", 32'(STALL_OUT), 32'd0);
    chk("stray_ack_wb", WB_DATA_OUT, 32'd0);
    chk("stray_ack_rdwe", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
    MEM_ACK = 1'b0;

    run_op("sb", 5'd3, 32'h0000_1003, 3'd0, 2'd1, 32'h0000_00A5, 1'b0, 1'b0, 1);
    chk("sb_mem", dmem[0][31:24], 32'h0000_00A5);

    set_word(0, 32'h80FF_7F01);
    run_op("lb", 5'd4, 32'h0000_2002, 3'd1, 2'd0, 32'd0, 1'b1, 1'b1, 1);
    chk("lb_value", WB_DATA_OUT, 32'hFFFF_FFFF);
    run_op("lbu", 5'd5, 32'h0000_2002, 3'd2, 2'd0, 32'd0, 1'b1, 1'b1, 1);
    chk("lbu_value", WB_DATA_OUT, 32'h0000_00FF);
    run_op("lh", 5'd6, 32'h0000_2002, 3'd3, 2'd0, 32'd0, 1'b1, 1'b1, 3);
    chk("lh_value", WB_DATA_OUT, 32'hFFFF_80FF);

    run_op("mis_lw", 5'd8, 32'h0000_3001, 3'd5, 2'd0, 32'd0, 1'b1, 1'b1, 1);
    drive_idle();
    @(negedge CLK);
    chk("mis_pulse_end", 32'(MISALIGNED), 32'd0);

    run_op("alu", 5'd7, 32'h0000_0055, 3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1);
    chk("alu_rd", 32'(RD_ADDRESS_OUT), 32'd7);
    chk("alu_wb", WB_DATA_OUT, 32'h0000_0055);
    run_op("sw", 5'd0, 32'h0000_1010, 3'd0, 2'd3, $urandom, 1'b0, 1'b0, 2);

    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [31:0] a;
      logic [2:0]  ld;
      logic [1:0]  st;
      kind = $urandom_range(0, 3);
      a    = 32'h0000_1000 + $urandom_range(0, 63);
      ld   = 3'd0;
      st   = 2'd0;
      case (kind)
        0: ld = (($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7);
        1: ld = 3'($urandom_range(1, 5));
        2: st = 2'($urandom_range(1, 3));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", n), 5'($urandom), a, ld, st, $urandom,
             (kind == 1) ? 1'($urandom) : 1'b0, 1'($urandom), $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
